ex_mem_pipe: RTL

Parametrised EX/MEM pipeline register. It carries each executed instruction's register writeback, HI/LO writeback and memory-access fields from the execute stage to the memory stage. It applies the pipeline-control stall vector and a flush, and holds the partial results of multi-cycle EX operations (madd/msub/div) while EX is stalled. It replaces the fixed 32-bit EX/MEM register and sits between the EX and MEM stages under the pipeline control unit.

---
 rtl/ex_mem_pipe_pkg.sv | 44 ++++
 rtl/ex_mem_pipe.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_pipe_pkg.sv
// Shared defines for the EX/MEM pipeline register: stall encodings, NOP
// constants and the per-edge update-mode decode.
package ex_mem_pipe_pkg;

    // Stall-vector bit encodings driven by the pipeline control unit
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Base widths; the pipeline register casts these to its own parameters
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned ALU_OP_W = 8;

    // Destination register used by a NOP (r0 is never written)
    localparam logic [REG_AW-1:0] NOP_REG_ADDR = '0;

    // All-zero data word
    localparam logic [WORD_W-1:0] ZERO_WORD = '0;

    // What the stage register does on the coming edge
    typedef enum logic [1:0] {
        UPD_ADVANCE = 2'd0,
        UPD_BUBBLE  = 2'd1,
        UPD_HOLD    = 2'd2,
        UPD_FLUSH   = 2'd3
    } upd_mode_e;

    // Flush dominates; a stalled EX either inserts a bubble or holds,
    // depending on whether MEM is stalled too.  A free EX always advances,
    // which also covers the illegal "EX free, MEM stalled" combination.
    function automatic upd_mode_e decode_mode(input logic flush,
                                              input logic ex_stop,
                                              input logic mem_stop);
        upd_mode_e mode;
        mode = UPD_ADVANCE;
        if (flush) begin
            mode = UPD_FLUSH;
        end else if (ex_stop == STOP) begin
            mode = (mem_stop == STOP) ? UPD_HOLD : UPD_BUBBLE;
        end
        return mode;
    endfunction

endpackage

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with stall/flush handling, multi-cycle EX
// feedback (hilo_tmp/cnt) and a saturating stall-cycle counter.
// Optional feature macro: EX_MEM_HILO_EN enables the HI/LO writeback path
// and the multi-cycle feedback registers; otherwise those outputs are 0.
module ex_mem_pipe
    import ex_mem_pipe_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned RADDR_W   = 5,
    parameter int unsigned AOP_W     = ALU_OP_W,
    parameter int unsigned STALL_W   = 6,
    parameter int unsigned STAGE_IDX = 3,
    parameter int unsigned SCNT_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush,
    input  logic                ex_valid,
    input  logic [RADDR_W-1:0]  ex_wd,
    input  logic                ex_wreg,
    input  logic [DATA_W-1:0]   ex_wdata,
    input  logic [AOP_W-1:0]    ex_aluop,
    input  logic [DATA_W-1:0]   ex_mem_addr,
    input  logic [DATA_W-1:0]   ex_reg2,
    input  logic                ex_whilo,
    input  logic [DATA_W-1:0]   ex_hi,
    input  logic [DATA_W-1:0]   ex_lo,
    input  logic [2*DATA_W-1:0] hilo_tmp_i,
    input  logic [1:0]          cnt_i,
    output logic                mem_valid,
    output logic [RADDR_W-1:0]  mem_wd,
    output logic                mem_wreg,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [AOP_W-1:0]    mem_aluop,
    output logic [DATA_W-1:0]   mem_mem_addr,
    output logic [DATA_W-1:0]   mem_reg2,
    output logic                mem_whilo,
    output logic [DATA_W-1:0]   mem_hi,
    output logic [DATA_W-1:0]   mem_lo,
    output logic [2*DATA_W-1:0] hilo_tmp_o,
    output logic [1:0]          cnt_o,
    output logic [SCNT_W-1:0]   stall_cnt
);

    localparam int unsigned MEM_IDX = STAGE_IDX + 1;
    localparam logic [SCNT_W-1:0]  SCNT_MAX  = {SCNT_W{1'b1}};
    localparam logic [SCNT_W-1:0]  SCNT_ONE  = SCNT_W'(1);
    localparam logic [DATA_W-1:0]  ZERO_D    = DATA_W'(ZERO_WORD);
    localparam logic [RADDR_W-1:0] NOP_WD    = RADDR_W'(NOP_REG_ADDR);

    upd_mode_e mode;

    // Only the EX and MEM bits of the stall vector matter here
    logic unused_stall;
    assign unused_stall = ^stall;

    // Per-edge update mode
    always_comb begin
        mode = decode_mode(flush, stall[STAGE_IDX], stall[MEM_IDX]);
    end

    // ------------------------------------------------------------------
    // Register-writeback and memory-access payload
    // ------------------------------------------------------------------
    logic                nxt_valid;
    logic [RADDR_W-1:0]  nxt_wd;
    logic                nxt_wreg;
    logic [DATA_W-1:0]   nxt_wdata;
    logic [AOP_W-1:0]    nxt_aluop;
    logic [DATA_W-1:0]   nxt_mem_addr;
    logic [DATA_W-1:0]   nxt_reg2;

    // Next payload: hold by default, NOP on flush/bubble, EX data on advance
    always_comb begin
        nxt_valid    = mem_valid;
        nxt_wd       = mem_wd;
        nxt_wreg     = mem_wreg;
        nxt_wdata    = mem_wdata;
        nxt_aluop    = mem_aluop;
        nxt_mem_addr = mem_mem_addr;
        nxt_reg2     = mem_reg2;
        unique case (mode)
            UPD_FLUSH, UPD_BUBBLE: begin
                nxt_valid    = 1'b0;
                nxt_wd       = NOP_WD;
                nxt_wreg     = 1'b0;
                nxt_wdata    = ZERO_D;
                nxt_aluop    = '0;
                nxt_mem_addr = ZERO_D;
                nxt_reg2     = ZERO_D;
            end
            UPD_ADVANCE: begin
                nxt_valid    = ex_valid;
                nxt_wd       = ex_wd;
                nxt_wreg     = ex_wreg;
                nxt_wdata    = ex_wdata;
                nxt_aluop    = ex_aluop;
                nxt_mem_addr = ex_mem_addr;
                nxt_reg2     = ex_reg2;
            end
            UPD_HOLD: begin
            end
            default: begin
            end
        endcase
    end

    // Payload register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_valid    <= 1'b0;
            mem_wd       <= NOP_WD;
            mem_wreg     <= 1'b0;
            mem_wdata    <= ZERO_D;
            mem_aluop    <= '0;
            mem_mem_addr <= ZERO_D;
            mem_reg2     <= ZERO_D;
        end else begin
            mem_valid    <= nxt_valid;
            mem_wd       <= nxt_wd;
            mem_wreg     <= nxt_wreg;
            mem_wdata    <= nxt_wdata;
            mem_aluop    <= nxt_aluop;
            mem_mem_addr <= nxt_mem_addr;
            mem_reg2     <= nxt_reg2;
        end
    end

    // ------------------------------------------------------------------
    // HI/LO writeback and multi-cycle feedback
    // ------------------------------------------------------------------
`ifdef EX_MEM_HILO_EN
    logic                nxt_whilo;
    logic [DATA_W-1:0]   nxt_hi;
    logic [DATA_W-1:0]   nxt_lo;
    logic [2*DATA_W-1:0] nxt_hilo_tmp;
    logic [1:0]          nxt_cnt;

    // HI/LO follows the payload; feedback is captured only while EX is stalled
    always_comb begin
        nxt_whilo    = mem_whilo;
        nxt_hi       = mem_hi;
        nxt_lo       = mem_lo;
        nxt_hilo_tmp = '0;
        nxt_cnt      = 2'd0;
        unique case (mode)
            UPD_FLUSH: begin
                nxt_whilo = 1'b0;
                nxt_hi    = ZERO_D;
                nxt_lo    = ZERO_D;
            end
            UPD_BUBBLE: begin
                nxt_whilo    = 1'b0;
                nxt_hi       = ZERO_D;
                nxt_lo       = ZERO_D;
                nxt_hilo_tmp = hilo_tmp_i;
                nxt_cnt      = cnt_i;
            end
            UPD_HOLD: begin
                nxt_hilo_tmp = hilo_tmp_i;
                nxt_cnt      = cnt_i;
            end
            UPD_ADVANCE: begin
                nxt_whilo = ex_whilo;
                nxt_hi    = ex_hi;
                nxt_lo    = ex_lo;
            end
            default: begin
            end
        endcase
    end

    // HI/LO and feedback register; reset drops any partial result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_whilo  <= 1'b0;
            mem_hi     <= ZERO_D;
            mem_lo     <= ZERO_D;
            hilo_tmp_o <= '0;
            cnt_o      <= 2'd0;
        end else begin
            mem_whilo  <= nxt_whilo;
            mem_hi     <= nxt_hi;
            mem_lo     <= nxt_lo;
            hilo_tmp_o <= nxt_hilo_tmp;
            cnt_o      <= nxt_cnt;
        end
    end
`else
    // HI/LO path absent: outputs constant, inputs absorbed
    logic unused_hilo;
    assign unused_hilo = ^{ex_whilo, ex_hi, ex_lo, hilo_tmp_i, cnt_i};

    assign mem_whilo  = 1'b0;
    assign mem_hi     = ZERO_D;
    assign mem_lo     = ZERO_D;
    assign hilo_tmp_o = '0;
    assign cnt_o      = 2'd0;
`endif

    // ------------------------------------------------------------------
    // Saturating count of consecutive EX stall cycles
    // ------------------------------------------------------------------
    logic [SCNT_W-1:0] nxt_stall_cnt;

    // Count up while EX is stalled, clear on advance or flush
    always_comb begin
        nxt_stall_cnt = '0;
        if ((mode == UPD_BUBBLE) || (mode == UPD_HOLD)) begin
            nxt_stall_cnt = (stall_cnt == SCNT_MAX) ? SCNT_MAX
                                                    : stall_cnt + SCNT_ONE;
        end
    end

    // Stall counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= nxt_stall_cnt;
        end
    end

`ifndef SYNTHESIS
    // Control unit must never stall MEM while letting EX advance
    illegal_stall_a: assert property (
        @(posedge clk) disable iff (!rst)
        !((stall[STAGE_IDX] == NO_STOP) && (stall[MEM_IDX] == STOP))
    );
`endif

endmodule
